// File: rtl/noc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_pkg : shared node mesh stream geometry (word, header and payload).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package noc_pkg;
   localparam int STREAM_WIDTH = 144;
   localparam int NET_WIDTH    = 4;
   localparam int PAYLOAD_W    = STREAM_WIDTH - NET_WIDTH;
   localparam int HDR_MSB      = STREAM_WIDTH - 1;
   localparam int HDR_LSB      = STREAM_WIDTH - NET_WIDTH;
   localparam int FANOUT_W     = 2;
   localparam int FIFO_DEPTH   = 4;
endpackage
`default_nettype wire

// File: rtl/inj_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inj_fifo : synchronous request queue with extra-MSB full/empty pointers. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module inj_fifo #(
   parameter int WIDTH = 146,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   import noc_pkg::*;

   localparam int c_AW = $clog2(DEPTH);

   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
endmodule
`default_nettype wire

// File: rtl/node_packet_injector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | node_packet_injector : queues core requests and streams fanout packets   |
// | {dest, payload} into the router local port.     Revision : 1.0           |
// +--------------------------------------------------------------------------+
module node_packet_injector #(
   parameter int STREAM_WIDTH = noc_pkg::STREAM_WIDTH,
   parameter int NET_WIDTH    = noc_pkg::NET_WIDTH,
   parameter int PAYLOAD_W    = noc_pkg::PAYLOAD_W,
   parameter int FANOUT_W     = noc_pkg::FANOUT_W,
   parameter int FIFO_DEPTH   = noc_pkg::FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [NET_WIDTH-1:0]    req_dest,
   input  logic [FANOUT_W-1:0]     req_fanout,
   input  logic [PAYLOAD_W-1:0]    req_payload,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [STREAM_WIDTH-1:0] out_stream,
   output logic                    busy,
   output logic [15:0]             sent_count
);
   import noc_pkg::*;

   localparam int         c_ENTRY_W  = NET_WIDTH + FANOUT_W + PAYLOAD_W;
   localparam logic [0:0] c_ST_IDLE  = 1'b0;
   localparam logic [0:0] c_ST_SEND  = 1'b1;

   logic [0:0]           r_state;
   logic                 r_out_valid;
   logic [NET_WIDTH-1:0] r_dest;
   logic [FANOUT_W-1:0]  r_remaining;
   logic [PAYLOAD_W-1:0] r_payload;
   logic [15:0]          r_sent_count;

   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [c_ENTRY_W-1:0] w_head;
   logic [NET_WIDTH-1:0] w_head_dest;
   logic [FANOUT_W-1:0]  w_head_fanout;
   logic [PAYLOAD_W-1:0] w_head_payload;
   logic                 w_handshake;
   logic                 w_last;
   logic                 w_pop;

   inj_fifo #(
      .WIDTH (c_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (req_valid),
      .i_wdata ({req_dest, req_fanout, req_payload}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign {w_head_dest, w_head_fanout, w_head_payload} = w_head;

   assign w_handshake = r_out_valid & out_ready;
   assign w_last      = (r_remaining == '0);

   // Pop on IDLE with work pending, or on the last packet's handshake for back-to-back.
   always_comb begin
      w_pop = 1'b0;
      if (r_state == c_ST_IDLE)
         w_pop = ~w_fifo_empty;
      else if (w_handshake && w_last)
         w_pop = ~w_fifo_empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_out_valid <= 1'b0;
         r_dest      <= '0;
         r_remaining <= '0;
         r_payload   <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (!w_fifo_empty) r_state <= c_ST_SEND;
            end
            c_ST_SEND: begin
               // First SEND cycle after IDLE only raises valid on the freshly loaded word.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (w_handshake) begin
                  if (!w_last) begin
                     r_dest      <= r_dest + 1'b1;
                     r_remaining <= r_remaining - 1'b1;
                  end else if (w_fifo_empty) begin
                     r_state     <= c_ST_IDLE;
                     r_out_valid <= 1'b0;
                  end
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase

         if (w_pop) begin
            r_dest      <= w_head_dest;
            r_remaining <= w_head_fanout;
            r_payload   <= w_head_payload;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sent_count <= '0;
      else if (w_handshake && (r_sent_count != 16'hFFFF))
         r_sent_count <= r_sent_count + 16'd1;
   end

   assign req_ready  = ~w_fifo_full;
   assign out_valid  = r_out_valid;
   assign out_stream = {r_dest, r_payload};
   assign busy       = (r_state == c_ST_SEND) | ~w_fifo_empty;
   assign sent_count = r_sent_count;
endmodule
`default_nettype wire
